// File: rtl/rr_arb_ctrl_if.sv
// rr_arb_ctrl_if -- request/grant bundle between requesters and rr_arb_ctrl.
//
// Signals:
//   req          N     level request vector (polarity set by the arbiter's ACT)
//   grant        N     registered one-hot grant, all zero when idle
//   grant_valid  1     high while exactly one grant bit is set
//   grant_id     ID_W  binary index of the current (or last) owner
//   handoff      1     one-cycle pulse on a direct owner-to-owner transfer
//
// Modports:
//   master  requester side (drives req, consumes the grant)
//   slave   arbiter side (consumes req, drives the grant)
interface rr_arb_ctrl_if #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) ();
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [ID_W-1:0] grant_id;
  logic            handoff;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  handoff
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output handoff
  );
endinterface

// File: rtl/rr_arb_ctrl.sv
// rr_arb_ctrl -- round-robin arbiter sharing one resource between N requesters.
//
// A rotating-priority search picks the winner among the active requests,
// starting at the priority pointer. The grant is registered and held until the
// owner drops its request; the pointer then moves past the released owner so it
// is searched last. A release with other requests pending hands the grant over
// directly (handoff pulse, no idle cycle).
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   arb    slave modport of rr_arb_ctrl_if (req in; grant, grant_valid,
//               grant_id, handoff out)
//
// Parameters:
//   N         number of requesters (>= 2)
//   ID_W      width of grant_id
//   ACT       active level of req (1 = active-high, 0 = active-low)
//   MAX_HOLD  maximum consecutive grant cycles per owner when the hold
//             limit is built in
//
// Build option:
//   RR_ARB_HOLD_LIMIT_EN  when defined, an owner that has held the grant for
//                         MAX_HOLD cycles is pre-empted if anyone else is
//                         requesting. When undefined, an owner holds the
//                         grant indefinitely.
module rr_arb_ctrl #(
  parameter int   N        = 4,
  parameter int   ID_W     = $clog2(N),
  parameter logic ACT      = 1'b1,
  parameter int   MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         reset,
  rr_arb_ctrl_if.slave arb
);

  if (N < 2 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_arb_ctrl: N must be >= 2 and MAX_HOLD must be >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N - 1);

  // Lowest set bit of {rv, rv} at or above sp, folded back into 0..N-1.
  // The double-width copy makes the circular search a plain priority encode.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0]    rv,
                                              input logic [ID_W-1:0] sp);
    logic [2*N-1:0]  dbl;
    logic            found;
    logic [ID_W-1:0] w;
    dbl   = {rv, rv};
    found = 1'b0;
    w     = '0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found && (j >= int'(sp)) && dbl[j]) begin
        found = 1'b1;
        w     = (j >= N) ? ID_W'(j - N) : ID_W'(j);
      end
    end
    return w;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? '0 : id + ID_W'(1);
  endfunction

  logic [N-1:0]    r;
  state_t          state_p1, state_n;
  logic [ID_W-1:0] ptr_p1, ptr_n;
  logic [N-1:0]    grant_p1, grant_n;
  logic            vld_p1, vld_n;
  logic [ID_W-1:0] id_p1, id_n;
  logic            handoff_p1, handoff_n;
  logic            any_r, release_c, preempt;
  logic [ID_W-1:0] after_owner, search_ptr, winner;

  // ---- stage 0: normalise requests and search for a winner ----
  assign r           = ACT ? arb.req : ~arb.req;
  assign any_r       = |r;
  assign after_owner = next_id(id_p1);
  assign release_c   = !r[id_p1] || preempt;
  // While busy the only search that matters is the one made on release, which
  // already uses the pointer value the release is about to install.
  assign search_ptr  = (state_p1 == BUSY) ? after_owner : ptr_p1;
  assign winner      = rr_pick(r, search_ptr);

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int              HC_W      = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] v);
    return (v >= HOLD_LAST) ? HOLD_LAST : v + HC_W'(1);
  endfunction

  logic [HC_W-1:0] hold_p1, hold_n;

  // Pre-emption only when someone other than the owner is waiting.
  assign preempt = (state_p1 == BUSY) && (hold_p1 == HOLD_LAST) &&
                   (|(r & ~onehot(id_p1)));
  // Counter restarts on every new grant and saturates while the owner keeps it.
  assign hold_n  = (state_p1 == BUSY && state_n == BUSY && !handoff_n) ?
                   sat_inc(hold_p1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_p1 <= '0;
    else       hold_p1 <= hold_n;
  end
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_n   = state_p1;
    ptr_n     = ptr_p1;
    grant_n   = grant_p1;
    vld_n     = vld_p1;
    id_n      = id_p1;
    handoff_n = 1'b0;
    case (state_p1)
      IDLE: begin
        if (any_r) begin
          state_n = BUSY;
          grant_n = onehot(winner);
          id_n    = winner;
          vld_n   = 1'b1;
        end
      end
      BUSY: begin
        if (release_c) begin
          ptr_n = after_owner;
          if (any_r) begin
            grant_n   = onehot(winner);
            id_n      = winner;
            handoff_n = 1'b1;
          end else begin
            state_n = IDLE;
            grant_n = '0;
            vld_n   = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- stage 1: registered grant ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1   <= IDLE;
      ptr_p1     <= '0;
      grant_p1   <= '0;
      vld_p1     <= 1'b0;
      id_p1      <= '0;
      handoff_p1 <= 1'b0;
    end else begin
      state_p1   <= state_n;
      ptr_p1     <= ptr_n;
      grant_p1   <= grant_n;
      vld_p1     <= vld_n;
      id_p1      <= id_n;
      handoff_p1 <= handoff_n;
    end
  end

  assign arb.grant       = grant_p1;
  assign arb.grant_valid = vld_p1;
  assign arb.grant_id    = id_p1;
  assign arb.handoff     = handoff_p1;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// tb_rr_arb_ctrl -- directed bench for rr_arb_ctrl (N=4).
// Two instances: u_dut with active-high requests, u_dut_n with active-low.
// Observed word per instance: {grant[3:0], grant_valid, grant_id[1:0], handoff}.
// Build option RR_ARB_HOLD_LIMIT_EN selects the matching hold-limit scenario.
module tb_rr_arb_ctrl;
  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  rr_arb_ctrl_if #(.N(4)) bus ();
  rr_arb_ctrl_if #(.N(4)) bus_n ();

  rr_arb_ctrl #(.N(4), .ID_W(2), .ACT(1'b1), .MAX_HOLD(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .arb   (bus)
  );

  rr_arb_ctrl #(.N(4), .ID_W(2), .ACT(1'b0), .MAX_HOLD(8)) u_dut_n (
    .clk   (clk),
    .reset (reset),
    .arb   (bus_n)
  );

  wire [7:0] obs   = {bus.grant, bus.grant_valid, bus.grant_id, bus.handoff};
  wire [7:0] obs_n = {bus_n.grant, bus_n.grant_valid, bus_n.grant_id, bus_n.handoff};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle; leaves time 1 unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    bus.req   = 4'b0000;
    bus_n.req = 4'b1111;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.req   = 4'b1111;
    bus_n.req = 4'b1111;
    tick();
    tick();
    vec_cnt++;
    if (obs !== 8'b0000_0_00_0) begin
      $display("FAIL reset_idle: got %b want %b (grant,valid,id,handoff)", obs, 8'b0000_0_00_0);
      err_cnt++;
    end
    vec_cnt++;
    if (obs_n !== 8'b0000_0_00_0) begin
      $display("FAIL reset_idle_actlow: got %b want %b (grant,valid,id,handoff)", obs_n, 8'b0000_0_00_0);
      err_cnt++;
    end
    reset   = 1'b0;
    bus.req = 4'b0100;
    tick();
    vec_cnt++;
    if (obs !== 8'b0100_1_10_0) begin
      $display("FAIL reset_release_grant: got %b want %b (grant,valid,id,handoff)", obs, 8'b0100_1_10_0);
      err_cnt++;
    end
    // Owner 2 drops; 3 is next after it, moving the pointer away from 0.
    bus.req = 4'b1001;
    tick();
    vec_cnt++;
    if (obs !== 8'b1000_1_11_1) begin
      $display("FAIL reset_pre_handoff: got %b want %b (grant,valid,id,handoff)", obs, 8'b1000_1_11_1);
      err_cnt++;
    end
    // Asynchronous clear mid-grant, checked before any clock edge.
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (obs !== 8'b0000_0_00_0) begin
      $display("FAIL reset_async_clear: got %b want %b (grant,valid,id,handoff)", obs, 8'b0000_0_00_0);
      err_cnt++;
    end
    tick();
    reset   = 1'b0;
    bus.req = 4'b1111;
    tick();
    vec_cnt++;
    if (obs !== 8'b0001_1_00_0) begin
      $display("FAIL reset_ptr_zero: got %b want %b (grant,valid,id,handoff)", obs, 8'b0001_1_00_0);
      err_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    bus.req = 4'b1010;
    tick();
    vec_cnt++;
    if (obs !== 8'b0010_1_01_0) begin
      $display("FAIL simul_first: got %b want %b (grant,valid,id,handoff)", obs, 8'b0010_1_01_0);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (obs !== 8'b0010_1_01_0) begin
      $display("FAIL simul_hold: got %b want %b (grant,valid,id,handoff)", obs, 8'b0010_1_01_0);
      err_cnt++;
    end
    bus.req = 4'b1000;
    tick();
    vec_cnt++;
    if (obs !== 8'b1000_1_11_1) begin
      $display("FAIL simul_handoff: got %b want %b (grant,valid,id,handoff)", obs, 8'b1000_1_11_1);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (obs !== 8'b1000_1_11_0) begin
      $display("FAIL simul_handoff_pulse: got %b want %b (grant,valid,id,handoff)", obs, 8'b1000_1_11_0);
      err_cnt++;
    end
    bus.req = 4'b0000;
    tick();
    vec_cnt++;
    if (obs !== 8'b0000_0_11_0) begin
      $display("FAIL simul_release: got %b want %b (grant,valid,id,handoff)", obs, 8'b0000_0_11_0);
      err_cnt++;
    end
    // Pointer now 0 (past owner 3): full request vector must pick 0.
    bus.req = 4'b1111;
    tick();
    vec_cnt++;
    if (obs !== 8'b0001_1_00_0) begin
      $display("FAIL simul_ptr_wrap: got %b want %b (grant,valid,id,handoff)", obs, 8'b0001_1_00_0);
      err_cnt++;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g  [4];
    logic [1:0] exp_id [4];
    exp_g  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id = '{2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    bus.req = 4'b1111;
    tick();
    vec_cnt++;
    if (obs !== 8'b0001_1_00_0) begin
      $display("FAIL rot_start: got %b want %b (grant,valid,id,handoff)", obs, 8'b0001_1_00_0);
      err_cnt++;
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.req = 4'b1111 & ~(4'b0001 << k);
      tick();
      vec_cnt++;
      if (obs !== {exp_g[k], 1'b1, exp_id[k], 1'b1}) begin
        $display("FAIL rot_handoff_%0d: got %b want %b (grant,valid,id,handoff)", k, obs, {exp_g[k], 1'b1, exp_id[k], 1'b1});
        err_cnt++;
      end
      bus.req = 4'b1111;
      tick();
      vec_cnt++;
      if (obs !== {exp_g[k], 1'b1, exp_id[k], 1'b0}) begin
        $display("FAIL rot_hold_%0d: got %b want %b (grant,valid,id,handoff)", k, obs, {exp_g[k], 1'b1, exp_id[k], 1'b0});
        err_cnt++;
      end
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_release_idle();
    apply_reset();
    bus.req = 4'b1000;
    tick();
    vec_cnt++;
    if (obs !== 8'b1000_1_11_0) begin
      $display("FAIL rel_grant3: got %b want %b (grant,valid,id,handoff)", obs, 8'b1000_1_11_0);
      err_cnt++;
    end
    bus.req = 4'b0000;
    tick();
    vec_cnt++;
    if (obs !== 8'b0000_0_11_0) begin
      $display("FAIL rel_idle: got %b want %b (grant,valid,id,handoff)", obs, 8'b0000_0_11_0);
      err_cnt++;
    end
    tick();
    vec_cnt++;
    if (obs !== 8'b0000_0_11_0) begin
      $display("FAIL rel_idle_stay: got %b want %b (grant,valid,id,handoff)", obs, 8'b0000_0_11_0);
      err_cnt++;
    end
    bus.req = 4'b0001;
    tick();
    vec_cnt++;
    if (obs !== 8'b0001_1_00_0) begin
      $display("FAIL rel_new_grant: got %b want %b (grant,valid,id,handoff)", obs, 8'b0001_1_00_0);
      err_cnt++;
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_act_low();
    apply_reset();
    bus_n.req = 4'b1101;
    tick();
    vec_cnt++;
    if (obs_n !== 8'b0010_1_01_0) begin
      $display("FAIL actlow_grant: got %b want %b (grant,valid,id,handoff)", obs_n, 8'b0010_1_01_0);
      err_cnt++;
    end
    bus_n.req = 4'b1111;
    tick();
    vec_cnt++;
    if (obs_n !== 8'b0000_0_01_0) begin
      $display("FAIL actlow_release: got %b want %b (grant,valid,id,handoff)", obs_n, 8'b0000_0_01_0);
      err_cnt++;
    end
  endtask

  task automatic test_hold_limit();
`ifdef RR_ARB_HOLD_LIMIT_EN
    apply_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0101;
    // Grant cycles 2..8 stay with owner 0.
    for (int k = 2; k <= 8; k++) begin
      tick();
      vec_cnt++;
      if (obs !== 8'b0001_1_00_0) begin
        $display("FAIL hold_keep_%0d: got %b want %b (grant,valid,id,handoff)", k, obs, 8'b0001_1_00_0);
        err_cnt++;
      end
    end
    tick();
    vec_cnt++;
    if (obs !== 8'b0100_1_10_1) begin
      $display("FAIL hold_preempt: got %b want %b (grant,valid,id,handoff)", obs, 8'b0100_1_10_1);
      err_cnt++;
    end
    apply_reset();
    bus.req = 4'b0001;
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      vec_cnt++;
      if (obs !== 8'b0001_1_00_0) begin
        $display("FAIL hold_alone_%0d: got %b want %b (grant,valid,id,handoff)", k, obs, 8'b0001_1_00_0);
        err_cnt++;
      end
    end
`else
    apply_reset();
    bus.req = 4'b0101;
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      vec_cnt++;
      if (obs !== 8'b0001_1_00_0) begin
        $display("FAIL hold_forever_%0d: got %b want %b (grant,valid,id,handoff)", k, obs, 8'b0001_1_00_0);
        err_cnt++;
      end
    end
`endif
    bus.req = 4'b0000;
    tick();
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    reset     = 1'b1;
    bus.req   = 4'b0000;
    bus_n.req = 4'b1111;
    test_reset();
    test_simultaneous();
    test_rotation();
    test_release_idle();
    test_act_low();
    test_hold_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
